// File: rtl/nibble_serial_subtractor_pkg.sv
// rtl/nibble_serial_subtractor_pkg.sv - shared ALU sequencer state encodings and nibble width
package nibble_serial_subtractor_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/subtractor_4bits.sv
// rtl/subtractor_4bits.sv - combinational 4-bit subtractor with borrow in/out
module subtractor_4bits (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       borrow_in,
  output logic [3:0] diff,
  output logic       borrow_out
);

  // The extra MSB wraps to 1 exactly when a - b - borrow_in goes negative.
  logic [4:0] full;

  assign full       = {1'b0, a} - {1'b0, b} - {4'b0000, borrow_in};
  assign diff       = full[3:0];
  assign borrow_out = full[4];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// rtl/nibble_serial_subtractor.sv - WIDTH-bit subtractor that reuses one 4-bit stage, one nibble per clock
module nibble_serial_subtractor
  import nibble_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_borrow,
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] out_sub,
  output logic             out_borrow,
  output logic             out_zero,
  output logic             out_ovf
);

  localparam int NIBBLES = WIDTH / NIBBLE;
  localparam int CW      = $clog2(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_e                  state;
  logic [CW-1:0]           cnt;
  logic [WIDTH-1:0]        sa;
  logic [WIDTH-1:0]        sb;
  // rs keeps only the upper WIDTH-4 result bits; the lowest nibble would always be shifted out.
  logic [WIDTH-NIBBLE-1:0] rs;
  logic                    br;
  logic                    a_msb;
  logic                    b_msb;

  logic [NIBBLE-1:0]       diff;
  logic                    stage_borrow;
  logic [WIDTH-1:0]        rs_next;

  subtractor_4bits u_stage (
    .a          (sa[NIBBLE-1:0]),
    .b          (sb[NIBBLE-1:0]),
    .borrow_in  (br),
    .diff       (diff),
    .borrow_out (stage_borrow)
  );

  assign rs_next = {diff, rs};

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sa         <= '0;
      sb         <= '0;
      rs         <= '0;
      br         <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      out_busy   <= 1'b0;
      out_done   <= 1'b0;
      out_sub    <= '0;
      out_borrow <= 1'b0;
      out_zero   <= 1'b0;
      out_ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          out_done <= 1'b0;
          if (in_start) begin
            sa       <= in_a;
            sb       <= in_b;
            br       <= in_borrow;
            a_msb    <= in_a[WIDTH-1];
            b_msb    <= in_b[WIDTH-1];
            cnt      <= '0;
            state    <= RUN;
            out_busy <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sa  <= sa >> NIBBLE;
          sb  <= sb >> NIBBLE;
          rs  <= rs_next[WIDTH-1:NIBBLE];
          br  <= stage_borrow;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            out_sub    <= rs_next;
            out_borrow <= stage_borrow;
            out_zero   <= (rs_next == '0);
            out_ovf    <= (a_msb != b_msb) && (rs_next[WIDTH-1] != a_msb);
            out_busy   <= 1'b0;
            out_done   <= 1'b1;
            state      <= DONE;
          end
        end
        default: begin
          state    <= IDLE;
          out_busy <= 1'b0;
          out_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb/tb_nibble_serial_subtractor.sv - scoreboard bench for nibble_serial_subtractor
module tb_nibble_serial_subtractor;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] sub;
    logic         borrow;
    logic         zero;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_busy;
  logic         out_done;
  logic [W-1:0] out_sub;
  logic         out_borrow;
  logic         out_zero;
  logic         out_ovf;

  res_t exp_q[$];
  res_t obs;
  res_t e;
  int   lat;
  int   busy_n;
  logic done0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  nibble_serial_subtractor #(.WIDTH(W)) dut (
    .in_clk     (clk),
    .in_rst_n   (rst_n),
    .in_start   (start),
    .in_a       (a),
    .in_b       (b),
    .in_borrow  (bin),
    .out_busy   (out_busy),
    .out_done   (out_done),
    .out_sub    (out_sub),
    .out_borrow (out_borrow),
    .out_zero   (out_zero),
    .out_ovf    (out_ovf)
  );

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] f;
    res_t r;
    f        = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
    r.sub    = f[W-1:0];
    r.borrow = f[W];
    r.zero   = (f[W-1:0] == '0);
    r.ovf    = (x[W-1] != y[W-1]) && (f[W-1] != x[W-1]);
    return r;
  endfunction

  // Drives one start, optionally injects a stray start at cycle glitch_at, waits for done.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                        input bit chained, input int glitch_at);
    if (!chained) @(negedge clk);
    start = 1'b1;
    a     = x;
    b     = y;
    bin   = c;
    exp_q.push_back(model(x, y, c));
    @(posedge clk);
    #1;
    start  = 1'b0;
    lat    = 0;
    busy_n = 0;
    done0  = 1'b0;
    while (lat < 20) begin
      @(negedge clk);
      if (lat == 0) done0 = out_done;
      if (out_busy) busy_n++;
      if (out_done && lat > 0) break;
      if (lat == glitch_at) begin
        start = 1'b1;
        a     = ~x;
        b     = x;
        bin   = ~c;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
    end
    obs = {out_sub, out_borrow, out_zero, out_ovf};
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({out_sub, out_borrow, out_zero, out_ovf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {out_sub, out_borrow, out_zero, out_ovf});
    end
    checks++;
    if ({out_busy, out_done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_handshake got %b want 00", {out_busy, out_done});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_op(16'h1234, 16'h0234, 1'b0, 1'b0, -1);
    e = exp_q.pop_front();
    checks++;
    if (obs !== {16'h1000, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_result got %h want %h", obs, {16'h1000, 3'b000});
    end
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL basic_model got %h want %h", obs, e);
    end
    checks++;
    if (lat !== 4 || busy_n !== 4) begin
      errors++;
      $display("FAIL basic_latency got lat %0d busy %0d want 4 4", lat, busy_n);
    end
    @(negedge clk);
    checks++;
    if (out_done !== 1'b0 || out_sub !== 16'h1000) begin
      errors++;
      $display("FAIL basic_done_fall got done %b sub %h want 0 1000", out_done, out_sub);
    end
  endtask

  task automatic test_underflow();
    run_op(16'h0000, 16'h0001, 1'b0, 1'b0, -1);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e || out_borrow !== 1'b1) begin
      errors++;
      $display("FAIL underflow got %h want %h", obs, e);
    end
    run_op(16'h0010, 16'h0000, 1'b1, 1'b0, -1);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e || out_sub !== 16'h000F) begin
      errors++;
      $display("FAIL borrow_in got %h want %h", obs, e);
    end
  endtask

  task automatic test_ovf_zero();
    run_op(16'h8000, 16'h0001, 1'b0, 1'b0, -1);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e || out_ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow got %h want %h", obs, e);
    end
    run_op(16'hABCD, 16'hABCD, 1'b0, 1'b0, -1);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e || out_zero !== 1'b1) begin
      errors++;
      $display("FAIL zero got %h want %h", obs, e);
    end
  endtask

  task automatic test_ignore_start();
    run_op(16'h4321, 16'h1111, 1'b0, 1'b0, 2);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL ignore_start_result got %h want %h", obs, e);
    end
    checks++;
    if (busy_n !== 4 || lat !== 4) begin
      errors++;
      $display("FAIL ignore_start_busy got busy %0d lat %0d want 4 4", busy_n, lat);
    end
  endtask

  task automatic test_back_to_back();
    run_op(16'h7000, 16'h9000, 1'b0, 1'b0, -1);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL b2b_first got %h want %h", obs, e);
    end
    run_op(16'h00FF, 16'h0F0F, 1'b1, 1'b1, -1);
    e = exp_q.pop_front();
    checks++;
    if (done0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_pulse got %b want 0", done0);
    end
    checks++;
    if (obs !== e || lat !== 4) begin
      errors++;
      $display("FAIL b2b_second got %h lat %0d want %h lat 4", obs, lat, e);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] x;
    logic [W-1:0] y;
    for (int i = 0; i < 4; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      run_op(x, y, 1'($urandom_range(1, 0)), 1'b0, -1);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL random_%0d got %h want %h", i, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    start = 1'b1;
    a     = 16'hFFFF;
    b     = 16'h0001;
    bin   = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_sub, out_borrow, out_zero, out_ovf, out_busy, out_done} !== '0) begin
      errors++;
      $display("FAIL mid_run_reset got %h want 0",
               {out_sub, out_borrow, out_zero, out_ovf, out_busy, out_done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h5A5A, 16'h1234, 1'b1, 1'b0, -1);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e || lat !== 4) begin
      errors++;
      $display("FAIL after_reset got %h lat %0d want %h lat 4", obs, lat, e);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_ovf_zero();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_subtractor.md
# nibble_serial_subtractor

Multi-cycle WIDTH-bit subtractor that feeds the 4-bit ripple subtractor stage one nibble per clock and consumes its output. Borrow is chained between nibbles through a register. It takes operands from the ALU operand latch under a start/done handshake and hands a registered difference and flags to the ALU result mux. It trades latency for area: one 4-bit datapath serves any WIDTH that is a multiple of 4.

## Interface
- WIDTH, 16: operand and result width. Must be a multiple of 4 and at least 8.
- in_clk  input  1  sole clock; all state changes on the rising edge.
- in_rst_n  input  1  reset, asynchronous, active-low.
- in_start  input  1  request a subtraction; sampled on the rising edge.
- in_a  input  WIDTH  minuend; captured on the accepted start edge.
- in_b  input  WIDTH  subtrahend; captured on the accepted start edge.
- in_borrow  input  1  borrow-in to nibble 0; captured on the accepted start edge.
- out_busy  output  1  high while in RUN.
- out_done  output  1  one-cycle pulse marking a new valid result.
- out_sub  output  WIDTH  registered difference in_a − in_b − in_borrow, mod 2^WIDTH.
- out_borrow  output  1  borrow out of the MSB nibble.
- out_zero  output  1  high when out_sub == 0.
- out_ovf  output  1  two's-complement overflow: (a[MSB] != b[MSB]) && (sub[MSB] != a[MSB]).

## Operation
- States: IDLE, RUN, DONE. Nibble counter cnt has ceil(log2(WIDTH/4)) bits.
- IDLE or DONE with in_start=1:
  - load shift registers sa←in_a, sb←in_b and borrow register br←in_borrow.
  - store a_msb and b_msb; set cnt=0; go to RUN.
- IDLE or DONE with in_start=0: IDLE holds; DONE goes to IDLE.
- RUN, every cycle:
  - the 4-bit stage gets sa[3:0], sb[3:0] and br.
  - its 4-bit difference shifts into the top of result shift register rs; rs shifts right by 4.
  - br←stage borrow-out; sa and sb shift right by 4; cnt increments.
- RUN with cnt == WIDTH/4−1:
  - out_sub←final rs value, out_borrow←final borrow, out_zero and out_ovf computed from the final value.
  - go to DONE.
- in_start during RUN is ignored; the operands are not captured and the operation is not restarted.
- out_sub and the flags hold the last result until the next completion; they do not change mid-operation.
- out_done=1 only in DONE. out_busy=1 only in RUN.
- A start in DONE is accepted (back-to-back operation); out_done is then high for exactly that one cycle.
- Borrow chaining equals a full WIDTH-bit subtraction. Unsigned underflow: out_borrow=1.

## Timing
- Reset (async assert): state=IDLE, cnt=0, sa/sb/rs/br=0, out_sub=0, out_borrow=0, out_zero=0, out_ovf=0, out_busy=0, out_done=0.
- Reset deassertion is synchronised externally; the first usable start edge is the first rising edge after release.
- Start accepted at edge t: out_busy=1 from t through t+WIDTH/4.
- The result and out_done are visible after edge t+WIDTH/4, so latency is WIDTH/4 cycles (4 for WIDTH=16).
- out_done falls after edge t+WIDTH/4+1, unless that edge accepts a new start.
- Throughput: one result per WIDTH/4+1 cycles with back-to-back starts.
- Reset asserted mid-RUN aborts immediately. All outputs go to reset values and the partial result is discarded.

## Structure
- A shared package/include holds the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and NIBBLE=4. It is shared with the other ALU sequencers.
- Sub-module: one instance of the existing subtractor_4bits as the combinational nibble datapath.
- The FSM, counter and shift registers live in this module.
- Estimated size: about 150–220 lines.

## Test plan
- 0x1234 − 0x0234, in_borrow=0 → out_sub=0x1000, out_borrow=0, zero=0, ovf=0; out_done exactly 4 cycles after the start edge.
- 0x0000 − 0x0001 → 0xFFFF, out_borrow=1, ovf=0. Then 0x0010 − 0x0000 with in_borrow=1 → 0x000F, out_borrow=0.
- 0x8000 − 0x0001 → 0x7FFF, ovf=1. 0xABCD − 0xABCD → 0x0000, zero=1, borrow=0.
- in_start pulsed mid-RUN with different operands → ignored; the first result is returned; out_busy is high for exactly 4 cycles.
- in_start held high in DONE → back-to-back operation. out_done is high for one cycle per result; the second result is correct and follows 4 cycles later.
- in_rst_n pulled low at cnt=2 → all outputs 0 asynchronously, state IDLE. A new start after release gives the correct result.
